// File: rtl/whack_judge_if.sv
// Mole-game bus: position handshake, player/timing inputs, display and score outputs.
// slave = whack_judge side, master = the surrounding game logic / bench.
interface whack_judge_if #(
   parameter int N_HOLES = 8,
   parameter int POS_W   = 3
);
   logic               tick;
   logic               start;
   logic               mole_valid;
   logic [POS_W-1:0]   mole_pos;
   logic [N_HOLES-1:0] whack;
   logic               mole_req;
   logic [N_HOLES-1:0] mole_show;
   logic               hit;
   logic               miss;
   logic [13:0]        score;
   logic [1:0]         lives;
   logic               game_over;
   logic               busy;

   modport slave (
      input  tick, start, mole_valid, mole_pos, whack,
      output mole_req, mole_show, hit, miss, score, lives, game_over, busy
   );

   modport master (
      output tick, start, mole_valid, mole_pos, whack,
      input  mole_req, mole_show, hit, miss, score, lives, game_over, busy
   );
endinterface

// File: rtl/whack_judge.sv
// Requests a mole, lights it, judges whacks against it and keeps score/lives; all outputs registered.
// hit/miss one cycle after the judged input; mole_req held until a valid in-range position arrives.
module whack_judge #(
   parameter int N_HOLES      = 8,
   parameter int POS_W        = 3,
   parameter int WINDOW_TICKS = 1000,
   parameter int GAP_TICKS    = 250,
   parameter int LIVES        = 3,
   parameter int SCORE_MAX    = 9999
) (
   input  logic         clk,
   input  logic         rst,
   whack_judge_if.slave bus
);
   localparam int TMAX = (WINDOW_TICKS > GAP_TICKS) ? WINDOW_TICKS : GAP_TICKS;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [13:0] SCORE_SAT = 14'(SCORE_MAX);
   localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

   typedef enum logic [2:0] {IDLE, REQ, ACTIVE, GAP, OVER} state_t;

   state_t             state, state_nxt;
   logic [TW-1:0]      timer, timer_nxt;
   logic               mole_req_r, mole_req_nxt;
   logic [N_HOLES-1:0] show_r, show_nxt;
   logic               hit_r, hit_nxt;
   logic               miss_r, miss_nxt;
   logic [13:0]        score_r, score_nxt;
   logic [1:0]         lives_r, lives_nxt;
   logic               over_r, over_nxt;
   logic               busy_r, busy_nxt;
   logic               do_hit, do_miss;
   logic               wrong_bit, right_bit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         timer      <= '0;
         mole_req_r <= 1'b0;
         show_r     <= '0;
         hit_r      <= 1'b0;
         miss_r     <= 1'b0;
         score_r    <= '0;
         lives_r    <= LIVES_INIT;
         over_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         mole_req_r <= mole_req_nxt;
         show_r     <= show_nxt;
         hit_r      <= hit_nxt;
         miss_r     <= miss_nxt;
         score_r    <= score_nxt;
         lives_r    <= lives_nxt;
         over_r     <= over_nxt;
         busy_r     <= busy_nxt;
      end
   end

   // show_r doubles as the latched one-hot position while ACTIVE.
   assign wrong_bit = |(bus.whack & ~show_r);
   assign right_bit = |(bus.whack & show_r);

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      show_nxt  = show_r;
      hit_nxt   = 1'b0;
      miss_nxt  = 1'b0;
      score_nxt = score_r;
      lives_nxt = lives_r;
      over_nxt  = over_r;
      do_hit    = 1'b0;
      do_miss   = 1'b0;

      case (state)
         IDLE, OVER: begin
            if (bus.start) begin
               score_nxt = '0;
               lives_nxt = LIVES_INIT;
               over_nxt  = 1'b0;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (mole_req_r && bus.mole_valid && (int'(bus.mole_pos) < N_HOLES)) begin
               show_nxt  = {{(N_HOLES-1){1'b0}}, 1'b1} << bus.mole_pos;
               timer_nxt = TW'(WINDOW_TICKS);
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (wrong_bit) begin
               do_miss = 1'b1;
            end else if (right_bit) begin
               do_hit = 1'b1;
            end else if (bus.tick) begin
               timer_nxt = timer - TW'(1);
               if (timer == TW'(1)) do_miss = 1'b1;
            end
         end
         GAP: begin
            if (bus.tick) begin
               timer_nxt = timer - TW'(1);
               if (timer == TW'(1)) state_nxt = REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (do_hit) begin
         hit_nxt   = 1'b1;
         score_nxt = (score_r >= SCORE_SAT) ? SCORE_SAT : score_r + 14'd1;
         show_nxt  = '0;
         timer_nxt = TW'(GAP_TICKS);
         state_nxt = GAP;
      end
      if (do_miss) begin
         miss_nxt  = 1'b1;
         show_nxt  = '0;
         lives_nxt = lives_r - 2'd1;
         if (lives_r == 2'd1) begin
            over_nxt  = 1'b1;
            timer_nxt = '0;
            state_nxt = OVER;
         end else begin
            timer_nxt = TW'(GAP_TICKS);
            state_nxt = GAP;
         end
      end

      mole_req_nxt = (state_nxt == REQ);
      busy_nxt     = (state_nxt == REQ) || (state_nxt == ACTIVE) || (state_nxt == GAP);
   end

   assign bus.mole_req  = mole_req_r;
   assign bus.mole_show = show_r;
   assign bus.hit       = hit_r;
   assign bus.miss      = miss_r;
   assign bus.score     = score_r;
   assign bus.lives     = lives_r;
   assign bus.game_over = over_r;
   assign bus.busy      = busy_r;
endmodule

// File: tb/tb_whack_judge.sv
// Directed bench for whack_judge: small window/gap/score limits so every boundary is reachable quickly.
module tb_whack_judge;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   whack_judge_if #(.N_HOLES(8), .POS_W(4)) bus ();

   whack_judge #(
      .N_HOLES(8), .POS_W(4), .WINDOW_TICKS(4), .GAP_TICKS(2), .LIVES(3), .SCORE_MAX(3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Tick until mole_req rises, with a cycle budget.
   task automatic wait_req();
      int n = 0;
      bus.tick = 1'b1;
      while (!bus.mole_req && n < 100) begin
         cyc();
         n++;
      end
      bus.tick = 1'b0;
      tests++;
      if (bus.mole_req !== 1'b1) begin
         $display("FAIL wait_req: mole_req=%b required 1 within 100 cycles", bus.mole_req);
         fails++;
      end
   endtask

   task automatic accept(input logic [3:0] p);
      wait_req();
      bus.mole_valid = 1'b1;
      bus.mole_pos   = p;
      cyc();
      bus.mole_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      tests++;
      if ({bus.mole_req, bus.mole_show, bus.hit, bus.miss, bus.game_over, bus.busy} !== 13'b0) begin
         $display("FAIL reset_ctl: req=%b show=%b hit=%b miss=%b over=%b busy=%b required all 0",
                  bus.mole_req, bus.mole_show, bus.hit, bus.miss, bus.game_over, bus.busy);
         fails++;
      end
      tests++;
      if (bus.score !== 14'd0 || bus.lives !== 2'd3) begin
         $display("FAIL reset_cnt: score=%0d lives=%0d required 0/3", bus.score, bus.lives);
         fails++;
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_accept();
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      tests++;
      if (bus.mole_req !== 1'b1 || bus.busy !== 1'b1) begin
         $display("FAIL start_req: req=%b busy=%b required 1/1", bus.mole_req, bus.busy);
         fails++;
      end
      bus.whack = 8'hFF;
      cyc();
      cyc();
      bus.whack = 8'h00;
      tests++;
      if (bus.mole_req !== 1'b1 || bus.miss !== 1'b0 || bus.hit !== 1'b0) begin
         $display("FAIL req_hold: req=%b hit=%b miss=%b required 1/0/0", bus.mole_req, bus.hit, bus.miss);
         fails++;
      end
      bus.mole_valid = 1'b1;
      bus.mole_pos   = 4'd5;
      cyc();
      bus.mole_valid = 1'b0;
      tests++;
      if (bus.mole_show !== 8'b0010_0000 || bus.mole_req !== 1'b0) begin
         $display("FAIL accept5: show=%b req=%b required 00100000/0", bus.mole_show, bus.mole_req);
         fails++;
      end
   endtask

   task automatic test_hit();
      bus.whack = 8'b0010_0000;
      cyc();
      bus.whack = 8'h00;
      tests++;
      if (bus.hit !== 1'b1 || bus.miss !== 1'b0 || bus.score !== 14'd1 || bus.mole_show !== 8'h00) begin
         $display("FAIL hit: hit=%b miss=%b score=%0d show=%b required 1/0/1/0",
                  bus.hit, bus.miss, bus.score, bus.mole_show);
         fails++;
      end
      cyc();
      tests++;
      if (bus.hit !== 1'b0) begin
         $display("FAIL hit_pulse: hit=%b required 0", bus.hit);
         fails++;
      end
      bus.tick = 1'b1;
      cyc();
      tests++;
      if (bus.mole_req !== 1'b0) begin
         $display("FAIL gap_early: req=%b required 0", bus.mole_req);
         fails++;
      end
      cyc();
      bus.tick = 1'b0;
      tests++;
      if (bus.mole_req !== 1'b1) begin
         $display("FAIL gap_end: req=%b required 1", bus.mole_req);
         fails++;
      end
   endtask

   task automatic test_wrong_wins();
      accept(4'd5);
      bus.whack = 8'b0010_0001;
      cyc();
      bus.whack = 8'h00;
      tests++;
      if (bus.miss !== 1'b1 || bus.hit !== 1'b0 || bus.lives !== 2'd2 || bus.score !== 14'd1) begin
         $display("FAIL wrong_wins: miss=%b hit=%b lives=%0d score=%0d required 1/0/2/1",
                  bus.miss, bus.hit, bus.lives, bus.score);
         fails++;
      end
   endtask

   task automatic test_timeout();
      accept(4'd5);
      bus.tick = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      tests++;
      if (bus.miss !== 1'b0) begin
         $display("FAIL timeout_early: miss=%b required 0 after 3 ticks", bus.miss);
         fails++;
      end
      cyc();
      bus.tick = 1'b0;
      tests++;
      if (bus.miss !== 1'b1 || bus.lives !== 2'd1 || bus.mole_show !== 8'h00) begin
         $display("FAIL timeout: miss=%b lives=%0d show=%b required 1/1/0", bus.miss, bus.lives, bus.mole_show);
         fails++;
      end
      accept(4'd5);
      bus.tick = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      bus.whack = 8'b0010_0000;
      cyc();
      bus.whack = 8'h00;
      bus.tick  = 1'b0;
      tests++;
      if (bus.hit !== 1'b1 || bus.miss !== 1'b0 || bus.score !== 14'd2) begin
         $display("FAIL last_tick_whack: hit=%b miss=%b score=%0d required 1/0/2", bus.hit, bus.miss, bus.score);
         fails++;
      end
   endtask

   task automatic test_game_over();
      accept(4'd3);
      bus.whack = 8'h01;
      cyc();
      bus.whack = 8'h00;
      tests++;
      if (bus.miss !== 1'b1 || bus.lives !== 2'd0 || bus.game_over !== 1'b1 || bus.busy !== 1'b0) begin
         $display("FAIL over: miss=%b lives=%0d over=%b busy=%b required 1/0/1/0",
                  bus.miss, bus.lives, bus.game_over, bus.busy);
         fails++;
      end
      bus.whack = 8'h04;
      bus.mole_valid = 1'b1;
      bus.mole_pos = 4'd2;
      bus.tick = 1'b1;
      cyc();
      cyc();
      bus.whack = 8'h00;
      bus.mole_valid = 1'b0;
      bus.tick = 1'b0;
      tests++;
      if (bus.mole_req !== 1'b0 || bus.mole_show !== 8'h00 || bus.miss !== 1'b0 || bus.hit !== 1'b0 ||
          bus.lives !== 2'd0 || bus.game_over !== 1'b1) begin
         $display("FAIL over_inert: req=%b show=%b hit=%b miss=%b lives=%0d over=%b required 0/0/0/0/0/1",
                  bus.mole_req, bus.mole_show, bus.hit, bus.miss, bus.lives, bus.game_over);
         fails++;
      end
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      tests++;
      if (bus.score !== 14'd0 || bus.lives !== 2'd3 || bus.mole_req !== 1'b1 || bus.game_over !== 1'b0 ||
          bus.busy !== 1'b1) begin
         $display("FAIL restart: score=%0d lives=%0d req=%b over=%b busy=%b required 0/3/1/0/1",
                  bus.score, bus.lives, bus.mole_req, bus.game_over, bus.busy);
         fails++;
      end
      // Three consecutive wrong whacks end the game.
      for (int i = 0; i < 3; i++) begin
         accept(4'(i + 1));
         bus.whack = 8'h80;
         cyc();
         bus.whack = 8'h00;
         tests++;
         if (bus.miss !== 1'b1 || bus.lives !== 2'(2 - i)) begin
            $display("FAIL miss_run%0d: miss=%b lives=%0d required 1/%0d", i, bus.miss, bus.lives, 2 - i);
            fails++;
         end
      end
      tests++;
      if (bus.game_over !== 1'b1 || bus.busy !== 1'b0) begin
         $display("FAIL miss_run_over: over=%b busy=%b required 1/0", bus.game_over, bus.busy);
         fails++;
      end
   endtask

   task automatic test_saturate_and_reset();
      logic [13:0] exp_score [4] = '{14'd1, 14'd2, 14'd3, 14'd3};
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         accept(4'(i));
         bus.whack = 8'(1 << i);
         cyc();
         bus.whack = 8'h00;
         tests++;
         if (bus.hit !== 1'b1 || bus.score !== exp_score[i]) begin
            $display("FAIL sat%0d: hit=%b score=%0d required 1/%0d", i, bus.hit, bus.score, exp_score[i]);
            fails++;
         end
      end
      wait_req();
      bus.mole_valid = 1'b1;
      bus.mole_pos = 4'd9;
      cyc();
      tests++;
      if (bus.mole_req !== 1'b1 || bus.mole_show !== 8'h00) begin
         $display("FAIL pos9: req=%b show=%b required 1/0", bus.mole_req, bus.mole_show);
         fails++;
      end
      bus.mole_pos = 4'd2;
      cyc();
      bus.mole_valid = 1'b0;
      tests++;
      if (bus.mole_show !== 8'h04 || bus.mole_req !== 1'b0) begin
         $display("FAIL pos2: show=%b req=%b required 00000100/0", bus.mole_show, bus.mole_req);
         fails++;
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      tests++;
      if (bus.mole_req !== 1'b0 || bus.mole_show !== 8'h00 || bus.hit !== 1'b0 || bus.miss !== 1'b0 ||
          bus.score !== 14'd0 || bus.lives !== 2'd3 || bus.game_over !== 1'b0 || bus.busy !== 1'b0) begin
         $display("FAIL mid_reset: req=%b show=%b hit=%b miss=%b score=%0d lives=%0d over=%b busy=%b",
                  bus.mole_req, bus.mole_show, bus.hit, bus.miss, bus.score, bus.lives, bus.game_over, bus.busy);
         fails++;
      end
   endtask

   initial begin
      bus.tick = 1'b0;
      bus.start = 1'b0;
      bus.mole_valid = 1'b0;
      bus.mole_pos = '0;
      bus.whack = '0;
      test_reset();
      test_accept();
      test_hit();
      test_wrong_wins();
      test_timeout();
      test_game_over();
      test_saturate_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
